mem_lsu_stage: RTL and testbench

MEM_LSU_STAGE -- requirements
Module: mem_lsu_stage

---
 rtl/mem_lsu_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_lsu_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_stage.sv
// Memory stage of the pipeline: issues data-memory loads/stores, waits on dmem_ready
// with a bounded timeout, formats load data, and registers the MEM/WB bundle.
//   state  | meaning
//   S_IDLE | accept from EX/MEM; issue aligned accesses combinationally
//   S_WAIT | access outstanding on latched request; pipeline stalled
module mem_lsu_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_MEM_valid,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [31:0] EX_MEM_pcPlus4,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_RegWrite,
    input  logic [1:0]  EX_MEM_ResultSrc,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [2:0]  EX_MEM_funct3,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        MEM_WB_valid,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_err,
    output logic [31:0] MEM_WB_ALU_result,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_pcPlus4,
    output logic [4:0]  MEM_WB_rd,
    output logic [1:0]  MEM_WB_ResultSrc
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;

    logic        lat_we, lat_rw, lat_load;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata, lat_alu, lat_pc4;
    logic [2:0]  lat_f3;
    logic [4:0]  lat_rd;
    logic [1:0]  lat_rs;

    logic        ex_mem_op, ex_aligned, ex_we, ex_load;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata;

    // MemWrite wins when both strobes are set, so such an op behaves as a store
    assign ex_mem_op = EX_MEM_valid & (EX_MEM_MemRead | EX_MEM_MemWrite) & ~flush;
    assign ex_we     = EX_MEM_MemWrite;
    assign ex_load   = EX_MEM_MemRead & ~EX_MEM_MemWrite;

    always_comb begin
        ex_aligned = 1'b1;
        ex_be      = 4'b1111;
        ex_wdata   = EX_MEM_WriteData;
        case (EX_MEM_funct3[1:0])
            2'b00: begin
                ex_be    = 4'b0001 << EX_MEM_ALU_result[1:0];
                ex_wdata = {4{EX_MEM_WriteData[7:0]}};
            end
            2'b01: begin
                ex_aligned = ~EX_MEM_ALU_result[0];
                ex_be      = 4'b0011 << EX_MEM_ALU_result[1:0];
                ex_wdata   = {2{EX_MEM_WriteData[15:0]}};
            end
            default: ex_aligned = (EX_MEM_ALU_result[1:0] == 2'b00);
        endcase
        if (!ex_we) begin
            ex_be    = 4'b1111;
            ex_wdata = 32'd0;
        end
    end

    logic        in_wait;
    logic        src_we, src_rw, src_load;
    logic [3:0]  src_be;
    logic [31:0] src_wdata, src_alu, src_pc4;
    logic [2:0]  src_f3;
    logic [4:0]  src_rd;
    logic [1:0]  src_rs;

    assign in_wait   = (state == S_WAIT);
    assign src_we    = in_wait ? lat_we    : ex_we;
    assign src_rw    = in_wait ? lat_rw    : EX_MEM_RegWrite;
    assign src_load  = in_wait ? lat_load  : ex_load;
    assign src_be    = in_wait ? lat_be    : ex_be;
    assign src_wdata = in_wait ? lat_wdata : ex_wdata;
    assign src_alu   = in_wait ? lat_alu   : EX_MEM_ALU_result;
    assign src_pc4   = in_wait ? lat_pc4   : EX_MEM_pcPlus4;
    assign src_f3    = in_wait ? lat_f3    : EX_MEM_funct3;
    assign src_rd    = in_wait ? lat_rd    : EX_MEM_rd;
    assign src_rs    = in_wait ? lat_rs    : EX_MEM_ResultSrc;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = dmem_rdata[{src_alu[1:0], 3'b000} +: 8];
        ld_half = dmem_rdata[{src_alu[1], 4'b0000} +: 16];
        case (src_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    logic        req_raw, stall_raw, done, err_load, pass;
    logic        nx_valid, nx_rw, nx_err;
    logic [31:0] nx_alu, nx_rdata, nx_pc4;
    logic [4:0]  nx_rd;
    logic [1:0]  nx_rs;

    always_comb begin
        state_nxt = state;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        done      = 1'b0;
        err_load  = 1'b0;
        pass      = 1'b0;
        if (state == S_IDLE) begin
            if (ex_mem_op && ex_aligned) begin
                req_raw = 1'b1;
                if (dmem_ready) begin
                    done = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    state_nxt = S_WAIT;
                end
            end else if (ex_mem_op) begin
                err_load = 1'b1;
            end else if (EX_MEM_valid && !flush) begin
                pass = 1'b1;
            end
        end else begin
            req_raw = 1'b1;
            if (dmem_ready) begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end else if (cnt == CNT_LAST) begin
                err_load  = 1'b1;
                state_nxt = S_IDLE;
            end else begin
                stall_raw = 1'b1;
            end
        end

        nx_valid = 1'b0;
        nx_rw    = 1'b0;
        nx_err   = 1'b0;
        nx_alu   = 32'd0;
        nx_rdata = 32'd0;
        nx_pc4   = 32'd0;
        nx_rd    = 5'd0;
        nx_rs    = 2'd0;
        if (done || err_load || pass) begin
            nx_valid = 1'b1;
            nx_rw    = src_rw & ~err_load;
            nx_err   = err_load;
            nx_alu   = src_alu;
            nx_rdata = (done && src_load) ? ld_data : 32'd0;
            nx_pc4   = src_pc4;
            nx_rd    = src_rd;
            nx_rs    = src_rs;
        end
    end

    // Reset must silence the bus immediately, even while EX/MEM still presents an op
    assign dmem_req   = req_raw & rst_n;
    assign mem_stall  = stall_raw & rst_n;
    assign dmem_we    = dmem_req & src_we;
    assign dmem_addr  = {src_alu[31:2], 2'b00};
    assign dmem_be    = src_be;
    assign dmem_wdata = src_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            cnt               <= '0;
            lat_we            <= 1'b0;
            lat_rw            <= 1'b0;
            lat_load          <= 1'b0;
            lat_be            <= 4'd0;
            lat_wdata         <= 32'd0;
            lat_alu           <= 32'd0;
            lat_pc4           <= 32'd0;
            lat_f3            <= 3'd0;
            lat_rd            <= 5'd0;
            lat_rs            <= 2'd0;
            MEM_WB_valid      <= 1'b0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_err        <= 1'b0;
            MEM_WB_ALU_result <= 32'd0;
            MEM_WB_ReadData   <= 32'd0;
            MEM_WB_pcPlus4    <= 32'd0;
            MEM_WB_rd         <= 5'd0;
            MEM_WB_ResultSrc  <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (in_wait && state_nxt == S_WAIT) ? cnt + CW'(1) : '0;
            if (!in_wait && state_nxt == S_WAIT) begin
                lat_we    <= ex_we;
                lat_rw    <= EX_MEM_RegWrite;
                lat_load  <= ex_load;
                lat_be    <= ex_be;
                lat_wdata <= ex_wdata;
                lat_alu   <= EX_MEM_ALU_result;
                lat_pc4   <= EX_MEM_pcPlus4;
                lat_f3    <= EX_MEM_funct3;
                lat_rd    <= EX_MEM_rd;
                lat_rs    <= EX_MEM_ResultSrc;
            end
            MEM_WB_valid      <= nx_valid;
            MEM_WB_RegWrite   <= nx_rw;
            MEM_WB_err        <= nx_err;
            MEM_WB_ALU_result <= nx_alu;
            MEM_WB_ReadData   <= nx_rdata;
            MEM_WB_pcPlus4    <= nx_pc4;
            MEM_WB_rd         <= nx_rd;
            MEM_WB_ResultSrc  <= nx_rs;
        end
    end
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: directed scenarios plus randomized ops
// compared against a per-transaction behavioural model of the memory stage.
module tb_mem_lsu_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_rw, ex_mr, ex_mw, flush, dmem_ready;
    logic [31:0] ex_alu, ex_wd, ex_pc4, dmem_rdata;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_rs;
    logic [2:0]  ex_f3;
    logic        dmem_req, dmem_we, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_rw, wb_err;
    logic [31:0] wb_alu, wb_rdata, wb_pc4;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_rs;

    int total = 0;
    int bad   = 0;

    mem_lsu_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_MEM_valid(ex_valid), .EX_MEM_ALU_result(ex_alu), .EX_MEM_WriteData(ex_wd),
        .EX_MEM_pcPlus4(ex_pc4), .EX_MEM_rd(ex_rd), .EX_MEM_RegWrite(ex_rw),
        .EX_MEM_ResultSrc(ex_rs), .EX_MEM_MemRead(ex_mr), .EX_MEM_MemWrite(ex_mw),
        .EX_MEM_funct3(ex_f3), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .MEM_WB_valid(wb_valid), .MEM_WB_RegWrite(wb_rw), .MEM_WB_err(wb_err),
        .MEM_WB_ALU_result(wb_alu), .MEM_WB_ReadData(wb_rdata), .MEM_WB_pcPlus4(wb_pc4),
        .MEM_WB_rd(wb_rd), .MEM_WB_ResultSrc(wb_rs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, wb_valid, wb_rw, wb_err, wb_rd[1:0], wb_rs}, 32'd0);
        chk({tag, "_alu"}, wb_alu, 32'd0);
        chk({tag, "_rdata"}, wb_rdata, 32'd0);
        chk({tag, "_pc4"}, wb_pc4, 32'd0);
        chk({tag, "_rd"}, {27'd0, wb_rd}, 32'd0);
    endtask

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * a[1:0]);
        case (f3)
            3'd0: return (sh[7:0] >= 8'd128) ? (sh & 32'hFF) | 32'hFFFF_FF00 : sh & 32'hFF;
            3'd4: return sh & 32'hFF;
            3'd1: return (sh[15:0] >= 16'h8000) ? (sh & 32'hFFFF) | 32'hFFFF_0000 : sh & 32'hFFFF;
            3'd5: return sh & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Drives one EX/MEM instruction, lets dmem_ready rise after `delay` waiting
    // cycles, and checks bus, stall and the resulting MEM/WB contents.
    task automatic do_op(input string tag, input bit v, input bit mr, input bit mw,
                         input bit fl, input bit flush_mid, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input bit rw, input logic [1:0] rs,
                         input int delay, input logic [31:0] rdat);
        bit          memop, aligned, issue, tout, lod;
        int          n_stall;
        logic [31:0] pc4, exp_wdata;
        logic [3:0]  exp_be;
        pc4 = $urandom;
        ex_valid = v; ex_mr = mr; ex_mw = mw; flush = fl; ex_f3 = f3; ex_alu = addr;
        ex_wd = wd; ex_rd = rd; ex_rw = rw; ex_rs = rs; ex_pc4 = pc4;

        memop   = v && (mr || mw) && !fl;
        aligned = (f3[1:0] == 2'd0) || (f3[1:0] == 2'd1 ? addr[0] == 1'b0 : addr[1:0] == 2'd0);
        issue   = memop && aligned;
        lod     = mr && !mw;
        tout    = issue && delay > T;
        n_stall = !issue ? 0 : (tout ? T : delay);
        exp_be  = 4'hF;
        exp_wdata = wd;
        if (mw && f3[1:0] == 2'd0) begin
            exp_be = 4'(1 << addr[1:0]);
            exp_wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
        end else if (mw && f3[1:0] == 2'd1) begin
            exp_be = 4'(3 << addr[1:0]);
            exp_wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
        end

        for (int idx = 0; idx <= n_stall; idx++) begin
            if (idx >= 1 && flush_mid) flush = 1'b1;
            dmem_ready = (idx == delay);
            dmem_rdata = (idx == delay) ? rdat : $urandom;
            @(negedge clk);
            chk({tag, "_req"}, {31'd0, dmem_req}, {31'd0, issue});
            chk({tag, "_stall"}, {31'd0, mem_stall}, {31'd0, issue && idx < n_stall});
            if (issue) begin
                chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, mw});
                if (mw) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
            end
            @(posedge clk); #1;
            if (idx < n_stall) chk_wb_zero({tag, "_bub"});
        end
        dmem_ready = 1'b0;
        flush = 1'b0;

        if (issue || memop || (v && !fl)) begin
            chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
            chk({tag, "_err"}, {31'd0, wb_err}, {31'd0, tout || (memop && !aligned)});
            chk({tag, "_rw"}, {31'd0, wb_rw}, {31'd0, rw && !tout && !(memop && !aligned)});
            chk({tag, "_rdata"}, wb_rdata, (issue && !tout && lod) ? fmt_load(f3, addr, rdat) : 32'd0);
            chk({tag, "_alu"}, wb_alu, addr);
            chk({tag, "_pc4"}, wb_pc4, pc4);
            chk({tag, "_rd_rs"}, {25'd0, wb_rd, wb_rs}, {25'd0, rd, rs});
        end else begin
            chk_wb_zero({tag, "_nop"});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {ex_valid, ex_rw, ex_mr, ex_mw, flush, dmem_ready} = '0;
        {ex_alu, ex_wd, ex_pc4, dmem_rdata} = '0;
        ex_rd = '0; ex_rs = '0; ex_f3 = '0;
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk_wb_zero("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        do_op("lw100", 1, 1, 0, 0, 0, 3'b010, 32'h100, 0, 5'd3, 1, 2'b01, 0, 32'hDEAD_BEEF);
        do_op("lb103", 1, 1, 0, 0, 0, 3'b000, 32'h103, 0, 5'd4, 1, 2'b01, 0, 32'h80FF_FFFF);
        do_op("lbu103", 1, 1, 0, 0, 0, 3'b100, 32'h103, 0, 5'd5, 1, 2'b01, 0, 32'h80FF_FFFF);
        do_op("lhu102", 1, 1, 0, 0, 0, 3'b101, 32'h102, 0, 5'd6, 1, 2'b01, 0, 32'h80FF_FFFF);
        do_op("sb201", 1, 0, 1, 0, 0, 3'b000, 32'h201, 32'hAB, 5'd0, 0, 2'b00, 3, 32'h0);
        do_op("lh101", 1, 1, 0, 0, 0, 3'b001, 32'h101, 0, 5'd7, 1, 2'b01, 0, 32'h1234_5678);
        do_op("tout", 1, 1, 0, 0, 1, 3'b010, 32'h40, 0, 5'd8, 1, 2'b01, 99, 32'h0);
        do_op("after_tout", 1, 1, 0, 0, 0, 3'b010, 32'h44, 0, 5'd9, 1, 2'b01, 1, 32'h0BAD_F00D);
        do_op("both_rw", 1, 1, 1, 0, 0, 3'b001, 32'h302, 32'h1234_CAFE, 5'd1, 0, 2'b00, 0, 32'h0);
        do_op("flush_idle", 1, 1, 0, 1, 0, 3'b010, 32'h80, 0, 5'd2, 1, 2'b01, 0, 32'h5);

        // Reset pulsed while an access is outstanding
        ex_valid = 1; ex_mr = 1; ex_mw = 0; ex_f3 = 3'b010; ex_alu = 32'h300; ex_rw = 1;
        dmem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("prerst_stall", {31'd0, mem_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
        chk_wb_zero("midrst");
        ex_valid = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        do_op("lw_postrst", 1, 1, 0, 0, 0, 3'b010, 32'h304, 0, 5'd10, 1, 2'b01, 2, 32'hA5A5_0001);

        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            do_op("rnd", $urandom_range(0, 7) != 0, kind == 1 || kind == 3, kind == 2 || kind == 3,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 2)), $urandom_range(0, T + 2), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
